// File: rtl/field_row_reader.sv
// Snapshots the occupancy field and active piece, then streams the composed rows one per handshake.
// Optional FIELD_ROW_READER_COLLISION_EN adds row_collision/frame_collision outputs.
module field_row_reader #(
    parameter int unsigned MEM_WIDTH  = 4,
    parameter int unsigned MEM_HEIGHT = 4,
    parameter int unsigned WIDTH      = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [MEM_WIDTH*MEM_HEIGHT-1:0]   field_bits,
    input  logic [4*WIDTH-1:0]                piece_x,
    input  logic [4*WIDTH-1:0]                piece_y,
    input  logic                              frame_req,
    output logic                              busy,
    output logic                              row_valid,
    input  logic                              row_ready,
    output logic [MEM_WIDTH-1:0]              row_data,
    output logic [WIDTH-1:0]                  row_idx,
    output logic                              row_full,
    output logic                              frame_done,
`ifdef FIELD_ROW_READER_COLLISION_EN
    output logic                              row_collision,
    output logic                              frame_collision,
`endif
    output logic [WIDTH-1:0]                  full_count
);

    typedef enum logic [1:0] {StIdle, StLoad, StEmit, StDone} state_e;

    state_e                            state_q;
    logic [MEM_WIDTH*MEM_HEIGHT-1:0]   snap_field_q;
    logic [4*WIDTH-1:0]                snap_x_q;
    logic [4*WIDTH-1:0]                snap_y_q;
    logic [WIDTH-1:0]                  acc_q;

    logic [WIDTH-1:0]      tgt_row;
    logic [MEM_WIDTH-1:0]  field_row;
    logic [MEM_WIDTH-1:0]  piece_row;
    logic [MEM_WIDTH-1:0]  comp_row;
    logic                  comp_coll;
    logic [WIDTH-1:0]      acc_next;
    logic                  handshake;
    logic                  last_row;

    // Compose the row that will be presented next: row 0 in LOAD, row_idx+1 in EMIT.
    always_comb begin
        tgt_row   = (state_q == StLoad) ? '0 : row_idx + WIDTH'(1);
        field_row = '0;
        piece_row = '0;
        for (int r = 0; r < MEM_HEIGHT; r++) begin
            if (tgt_row == WIDTH'(r)) begin
                field_row = snap_field_q[r*MEM_WIDTH +: MEM_WIDTH];
            end
        end
        // Matching only in-range columns drops out-of-range cells without wrapping.
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < MEM_WIDTH; c++) begin
                if (snap_x_q[i*WIDTH +: WIDTH] == WIDTH'(c) &&
                    snap_y_q[i*WIDTH +: WIDTH] == tgt_row) begin
                    piece_row[c] = 1'b1;
                end
            end
        end
        comp_row  = field_row | piece_row;
        comp_coll = |(field_row & piece_row);
        acc_next  = (row_full && (acc_q != '1)) ? acc_q + WIDTH'(1) : acc_q;
        handshake = row_valid && row_ready;
        last_row  = (row_idx == WIDTH'(MEM_HEIGHT - 1));
    end

`ifdef FIELD_ROW_READER_COLLISION_EN
    logic coll_acc_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            snap_field_q <= '0;
            snap_x_q     <= '0;
            snap_y_q     <= '0;
            acc_q        <= '0;
            busy         <= 1'b0;
            row_valid    <= 1'b0;
            row_data     <= '0;
            row_idx      <= '0;
            row_full     <= 1'b0;
            frame_done   <= 1'b0;
            full_count   <= '0;
`ifdef FIELD_ROW_READER_COLLISION_EN
            row_collision   <= 1'b0;
            frame_collision <= 1'b0;
            coll_acc_q      <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (frame_req) begin
                        snap_field_q <= field_bits;
                        snap_x_q     <= piece_x;
                        snap_y_q     <= piece_y;
                        busy         <= 1'b1;
                        state_q      <= StLoad;
                    end
                end
                StLoad: begin
                    row_data  <= comp_row;
                    row_idx   <= '0;
                    row_full  <= &comp_row;
                    row_valid <= 1'b1;
                    acc_q     <= '0;
`ifdef FIELD_ROW_READER_COLLISION_EN
                    row_collision <= comp_coll;
                    coll_acc_q    <= 1'b0;
`endif
                    state_q   <= StEmit;
                end
                StEmit: begin
                    if (handshake) begin
                        acc_q <= acc_next;
`ifdef FIELD_ROW_READER_COLLISION_EN
                        coll_acc_q <= coll_acc_q | row_collision;
`endif
                        if (last_row) begin
                            row_valid  <= 1'b0;
                            frame_done <= 1'b1;
                            full_count <= acc_next;
`ifdef FIELD_ROW_READER_COLLISION_EN
                            frame_collision <= coll_acc_q | row_collision;
`endif
                            state_q    <= StDone;
                        end else begin
                            row_data <= comp_row;
                            row_idx  <= tgt_row;
                            row_full <= &comp_row;
`ifdef FIELD_ROW_READER_COLLISION_EN
                            row_collision <= comp_coll;
`endif
                        end
                    end
                end
                StDone: begin
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifndef FIELD_ROW_READER_COLLISION_EN
    logic unused_coll;
    assign unused_coll = comp_coll;
`endif

endmodule

// File: tb/tb_field_row_reader.sv
// Scoreboard bench for field_row_reader: expected rows/counts queued at frame request,
// compared as rows are accepted and frames complete.
module tb_field_row_reader;

    localparam int MW = 4;
    localparam int MH = 4;
    localparam int W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [MW*MH-1:0]  field_bits;
    logic [4*W-1:0]    piece_x;
    logic [4*W-1:0]    piece_y;
    logic              frame_req;
    logic              busy;
    logic              row_valid;
    logic              row_ready;
    logic [MW-1:0]     row_data;
    logic [W-1:0]      row_idx;
    logic              row_full;
    logic              frame_done;
    logic [W-1:0]      full_count;
`ifdef FIELD_ROW_READER_COLLISION_EN
    logic              row_collision;
    logic              frame_collision;
`endif

    field_row_reader #(.MEM_WIDTH(MW), .MEM_HEIGHT(MH), .WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .field_bits (field_bits),
        .piece_x    (piece_x),
        .piece_y    (piece_y),
        .frame_req  (frame_req),
        .busy       (busy),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .row_data   (row_data),
        .row_idx    (row_idx),
        .row_full   (row_full),
        .frame_done (frame_done),
`ifdef FIELD_ROW_READER_COLLISION_EN
        .row_collision   (row_collision),
        .frame_collision (frame_collision),
`endif
        .full_count (full_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [MW-1:0] data;
        logic [W-1:0]  idx;
        logic          full;
        logic          coll;
    } row_t;

    row_t        exp_rows[$];
    logic [W:0]  exp_done[$];   // {frame collision, full count}

    int n_checks = 0;
    int n_errors = 0;
    int done_count = 0;
    int ready_mode = 0;          // 0: always ready, 1: toggle every cycle
    logic        stall_q = 1'b0;
    logic [31:0] held;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4*W-1:0] pk(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c, input logic [W-1:0] d);
        return {d, c, b, a};
    endfunction

    // Reference model: paint piece cells onto a flat map, then slice rows.
    task automatic push_frame(input logic [MW*MH-1:0] f, input logic [4*W-1:0] px,
                              input logic [4*W-1:0] py);
        logic [MW*MH-1:0] pm;
        logic [MW*MH-1:0] comp;
        logic [W-1:0]     x;
        logic [W-1:0]     y;
        row_t             e;
        int               nfull;
        logic             fcoll;
        pm = '0;
        for (int i = 0; i < 4; i++) begin
            x = px[i*W +: W];
            y = py[i*W +: W];
            if (x < MW && y < MH) pm[y*MW + x] = 1'b1;
        end
        comp  = f | pm;
        nfull = 0;
        fcoll = 1'b0;
        for (int r = 0; r < MH; r++) begin
            e.data = comp[r*MW +: MW];
            e.idx  = W'(r);
            e.full = (e.data == {MW{1'b1}});
            e.coll = |(f[r*MW +: MW] & pm[r*MW +: MW]);
            if (e.full) nfull++;
            fcoll  = fcoll | e.coll;
            exp_rows.push_back(e);
        end
        exp_done.push_back({fcoll, W'(nfull)});
    endtask

    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) row_ready = 1'b1;
        else                 row_ready = ~row_ready;
    end

    always @(negedge clk) begin
        row_t        e;
        logic [W:0]  d;
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) check("stall_hold", {19'd0, row_data, row_idx, row_full}, held);
            stall_q = row_valid && !row_ready;
            held    = {19'd0, row_data, row_idx, row_full};
            if (row_valid && row_ready) begin
                if (exp_rows.size() == 0) begin
                    check("extra_row", 32'(row_idx), 32'hFFFF_FFFF);
                end else begin
                    e = exp_rows.pop_front();
                    check("row_idx", 32'(row_idx), 32'(e.idx));
                    check("row_data", 32'(row_data), 32'(e.data));
                    check("row_full", 32'(row_full), 32'(e.full));
`ifdef FIELD_ROW_READER_COLLISION_EN
                    check("row_collision", 32'(row_collision), 32'(e.coll));
`endif
                end
            end
            if (frame_done) begin
                done_count++;
                if (exp_done.size() == 0) begin
                    check("extra_frame_done", 32'(full_count), 32'hFFFF_FFFF);
                end else begin
                    d = exp_done.pop_front();
                    check("full_count", 32'(full_count), 32'(d[W-1:0]));
                    check("done_busy", 32'(busy), 32'd1);
`ifdef FIELD_ROW_READER_COLLISION_EN
                    check("frame_collision", 32'(frame_collision), 32'(d[W]));
`endif
                end
            end
        end
    end

    task automatic start_frame(input logic [MW*MH-1:0] f, input logic [4*W-1:0] px,
                               input logic [4*W-1:0] py);
        @(posedge clk);
        #1;
        field_bits = f;
        piece_x    = px;
        piece_y    = py;
        frame_req  = 1'b1;
        push_frame(f, px, py);
        @(posedge clk);
        #1;
        frame_req = 1'b0;
        @(negedge clk);
        check("load_busy", 32'(busy), 32'd1);
        check("load_no_valid", 32'(row_valid), 32'd0);
        @(negedge clk);
        check("first_valid_latency", 32'(row_valid), 32'd1);
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 100; i++) begin
            if (done_count >= target) break;
            @(negedge clk);
        end
        check("done_timeout", 32'(done_count >= target), 32'd1);
    endtask

    initial begin
        int dc;
        rst        = 1'b1;
        frame_req  = 1'b1;
        row_ready  = 1'b1;
        field_bits = '0;
        piece_x    = pk(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        piece_y    = pk(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        repeat (4) @(posedge clk);
        #1;
        rst       = 1'b0;
        frame_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_outputs",
                  {11'd0, busy, row_valid, frame_done, full_count, row_data, row_idx, row_full},
                  32'd0);
        end

        // Piece fills the bottom row of an empty field.
        ready_mode = 0;
        start_frame(16'h0000, pk(0, 1, 2, 3), pk(3, 3, 3, 3));
        wait_done(1);

        // Stalling consumer, out-of-range cell, and a frame_req/field change mid-frame.
        ready_mode = 1;
        start_frame(16'hF0F0, pk(0, 1, 0, 5), pk(0, 0, 1, 0));
        @(posedge clk);
        #1;
        frame_req  = 1'b1;
        field_bits = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        frame_req = 1'b0;
        wait_done(2);
        repeat (6) @(negedge clk);
        check("single_done", 32'(done_count), 32'd2);
        check("no_retrigger_busy", 32'(busy), 32'd0);
        check("no_retrigger_valid", 32'(row_valid), 32'd0);

        // Abort at row 2 with two full rows already counted.
        ready_mode = 0;
        dc = done_count;
        start_frame(16'h00FF, pk(8'hFF, 8'hFF, 8'hFF, 8'hFF), pk(0, 0, 0, 0));
        for (int i = 0; i < 20; i++) begin
            if (row_valid && row_idx == 8'd2) break;
            @(negedge clk);
        end
        check("reach_row2", 32'(row_idx), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        check("abort_valid", 32'(row_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(frame_done), 32'd0);
        rst = 1'b0;
        exp_rows.delete();
        exp_done.delete();
        repeat (4) @(negedge clk);
        check("abort_no_done", 32'(done_count), 32'(dc));

        start_frame(16'hF000, pk(8'hFF, 8'hFF, 8'hFF, 8'hFF), pk(0, 0, 0, 0));
        wait_done(dc + 1);

`ifdef FIELD_ROW_READER_COLLISION_EN
        start_frame(16'h0001, pk(0, 8'hFF, 8'hFF, 8'hFF), pk(0, 0, 0, 0));
        wait_done(dc + 2);
        start_frame(16'h0001, pk(1, 8'hFF, 8'hFF, 8'hFF), pk(0, 0, 0, 0));
        wait_done(dc + 3);
`endif

        repeat (4) @(negedge clk);
        check("rows_drained", 32'(exp_rows.size()), 32'd0);
        check("end_idle", {30'd0, busy, row_valid}, 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
